// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780 byte writer.
//   lcd_state_e   - controller state encoding
//   INIT_LEN/ROM  - power-on command list used when LCD_INIT_SEQ_EN is defined
//   SLOW_CMD_MASK - command bits that must be clear for a Clear/Home command
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SETUP = 3'd2,
    ST_EN_HI = 3'd3,
    ST_EXEC  = 3'd4
  } lcd_state_e;

  localparam int unsigned INIT_LEN   = 4;
  localparam int unsigned INIT_IDX_W = 2;

  // Byte 0 sits in the low byte: function set, display on, entry mode, clear.
  localparam logic [INIT_LEN*8-1:0] INIT_ROM = {8'h01, 8'h06, 8'h0C, 8'h38};

  // Clear (0x01) and Home (0x02/0x03) have every bit above bit 1 clear.
  // 0x00 also matches and is treated as slow, which is the safe choice.
  localparam logic [7:0] SLOW_CMD_MASK = 8'hFC;

  function automatic logic [7:0] init_byte(input logic [INIT_IDX_W-1:0] idx);
    return INIT_ROM[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && ((data & SLOW_CMD_MASK) == 8'h00);
  endfunction

endpackage

// File: rtl/lcd_byte_writer_timer.sv
// lcd_delay_timer: loadable down-counter that saturates at zero.
//   clk, rst_n - clock, asynchronous active-low reset (count <- RST_VAL)
//   load       - load load_val this cycle (wins over decrement)
//   load_val   - value to load
//   done       - count currently reads zero
module lcd_delay_timer #(
  parameter int unsigned W       = 8,
  parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_r;

  // Count register: load on request, otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= RST_VAL;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {W{1'b0}}) begin
      cnt_r <= cnt_r - W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: 8-bit write-only HD44780 bus driver.
// Accepts bytes on a valid/ready handshake and produces RS/data setup,
// the E pulse and the post-write execution wait, all in units of one
// microsecond = TICK_DIV clk cycles.
//   clk, rst_n         - clock, asynchronous active-low reset
//   wr_valid/wr_ready  - request handshake; accepted when both high at posedge
//   wr_rs, wr_data     - 0 = command / 1 = data, and the byte to write
//   init_done          - sticky: power-up (and optional init list) finished
//   lcd_rs, lcd_rw, lcd_en, lcd_data - LCD pins (lcd_rw tied low)
// Build option: define LCD_INIT_SEQ_EN to have the block send the init
// command list (0x38, 0x0C, 0x06, 0x01) itself after power-up.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50,
  parameter int unsigned POWERUP_US   = 15000,
  parameter int unsigned SETUP_US     = 1,
  parameter int unsigned E_HIGH_US    = 1,
  parameter int unsigned EXEC_US      = 40,
  parameter int unsigned SLOW_EXEC_US = 1640
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam int unsigned PWR_CYC  = POWERUP_US * TICK_DIV;
  localparam int unsigned SLOW_CYC = SLOW_EXEC_US * TICK_DIV;
  localparam int unsigned MAX_CYC  = (PWR_CYC > SLOW_CYC) ? PWR_CYC : SLOW_CYC;
  localparam int unsigned CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Load values are N*TICK_DIV-1 so that a state lasts exactly N*TICK_DIV cycles.
  localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(PWR_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_US * TICK_DIV - 1);
  localparam logic [CNT_W-1:0] EN_HI_LD = CNT_W'(E_HIGH_US * TICK_DIV - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_US * TICK_DIV - 1);
  localparam logic [CNT_W-1:0] SLOW_LD  = CNT_W'(SLOW_CYC - 1);

  lcd_state_e       state_r;
  lcd_state_e       state_nx;
  logic             tmr_load_s;
  logic [CNT_W-1:0] tmr_val_s;
  logic             tmr_done_s;
  logic             latch_s;
  logic             latch_rs_s;
  logic [7:0]       latch_data_s;
  logic             lcd_rs_r;
  logic [7:0]       lcd_data_r;
  logic             lcd_en_r;
  logic             wr_ready_r;
  logic             init_done_r;

`ifdef LCD_INIT_SEQ_EN
  localparam logic [INIT_IDX_W-1:0] INIT_LAST = INIT_IDX_W'(INIT_LEN - 1);
  logic                  init_active_r;
  logic [INIT_IDX_W-1:0] init_idx_r;
  logic                  init_adv_s;
  logic                  init_end_s;
`endif

  // The timer starts out loaded with the power-up wait, so PWRUP needs no entry load.
  lcd_delay_timer #(
    .W       (CNT_W),
    .RST_VAL (PWRUP_LD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .done     (tmr_done_s)
  );

  // Next-state logic: picks the next state, the timer load for it and any byte to latch.
  always_comb begin
    state_nx     = state_r;
    tmr_load_s   = 1'b0;
    tmr_val_s    = {CNT_W{1'b0}};
    latch_s      = 1'b0;
    latch_rs_s   = 1'b0;
    latch_data_s = 8'h00;
`ifdef LCD_INIT_SEQ_EN
    init_adv_s   = 1'b0;
    init_end_s   = 1'b0;
`endif
    case (state_r)
      ST_PWRUP: begin
        if (tmr_done_s) begin
`ifdef LCD_INIT_SEQ_EN
          // The init list runs through the normal write path, starting with byte 0.
          state_nx     = ST_SETUP;
          tmr_load_s   = 1'b1;
          tmr_val_s    = SETUP_LD;
          latch_s      = 1'b1;
          latch_rs_s   = 1'b0;
          latch_data_s = init_byte(init_idx_r);
`else
          state_nx = ST_IDLE;
`endif
        end else begin
          state_nx = ST_PWRUP;
        end
      end
      ST_IDLE: begin
        if (wr_valid && wr_ready_r) begin
          state_nx     = ST_SETUP;
          tmr_load_s   = 1'b1;
          tmr_val_s    = SETUP_LD;
          latch_s      = 1'b1;
          latch_rs_s   = wr_rs;
          latch_data_s = wr_data;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (tmr_done_s) begin
          state_nx   = ST_EN_HI;
          tmr_load_s = 1'b1;
          tmr_val_s  = EN_HI_LD;
        end else begin
          state_nx = ST_SETUP;
        end
      end
      ST_EN_HI: begin
        if (tmr_done_s) begin
          state_nx   = ST_EXEC;
          tmr_load_s = 1'b1;
          // Wait length follows the byte actually on the bus, not the live input.
          tmr_val_s  = is_slow_cmd(lcd_rs_r, lcd_data_r) ? SLOW_LD : EXEC_LD;
        end else begin
          state_nx = ST_EN_HI;
        end
      end
      ST_EXEC: begin
        if (tmr_done_s) begin
`ifdef LCD_INIT_SEQ_EN
          if (init_active_r && (init_idx_r != INIT_LAST)) begin
            state_nx     = ST_SETUP;
            tmr_load_s   = 1'b1;
            tmr_val_s    = SETUP_LD;
            latch_s      = 1'b1;
            latch_rs_s   = 1'b0;
            latch_data_s = init_byte(init_idx_r + INIT_IDX_W'(1'b1));
            init_adv_s   = 1'b1;
          end else if (init_active_r) begin
            state_nx   = ST_IDLE;
            init_end_s = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
`else
          state_nx = ST_IDLE;
`endif
        end else begin
          state_nx = ST_EXEC;
        end
      end
      default: begin
        state_nx   = ST_PWRUP;
        tmr_load_s = 1'b1;
        tmr_val_s  = PWRUP_LD;
      end
    endcase
  end

  // State and output registers; outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_PWRUP;
      lcd_rs_r    <= 1'b0;
      lcd_data_r  <= 8'h00;
      lcd_en_r    <= 1'b0;
      wr_ready_r  <= 1'b0;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_nx;
      lcd_en_r    <= (state_nx == ST_EN_HI);
      wr_ready_r  <= (state_nx == ST_IDLE);
      init_done_r <= init_done_r | (state_nx == ST_IDLE);
      if (latch_s) begin
        lcd_rs_r   <= latch_rs_s;
        lcd_data_r <= latch_data_s;
      end else begin
        lcd_rs_r   <= lcd_rs_r;
        lcd_data_r <= lcd_data_r;
      end
    end
  end

`ifdef LCD_INIT_SEQ_EN
  // Init list position; the list is active from reset until its last wait ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_active_r <= 1'b1;
      init_idx_r    <= {INIT_IDX_W{1'b0}};
    end else if (init_adv_s) begin
      init_active_r <= init_active_r;
      init_idx_r    <= init_idx_r + INIT_IDX_W'(1'b1);
    end else if (init_end_s) begin
      init_active_r <= 1'b0;
      init_idx_r    <= init_idx_r;
    end else begin
      init_active_r <= init_active_r;
      init_idx_r    <= init_idx_r;
    end
  end
`endif

  assign wr_ready  = wr_ready_r;
  assign init_done = init_done_r;
  assign lcd_rs    = lcd_rs_r;
  assign lcd_rw    = 1'b0;
  assign lcd_en    = lcd_en_r;
  assign lcd_data  = lcd_data_r;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Self-checking bench for lcd_byte_writer with small timing parameters.
// Works with or without LCD_INIT_SEQ_EN defined.
module tb_lcd_byte_writer;

  localparam int TICK = 2;
  localparam int PWR  = 10;
  localparam int SU   = 1;
  localparam int EH   = 1;
  localparam int EX   = 4;
  localparam int SL   = 20;
  localparam int PW_CYC  = PWR * TICK;
  localparam int MAX_LAT = 200;

`ifdef LCD_INIT_SEQ_EN
  localparam int N_INIT = 4;
`else
  localparam int N_INIT = 0;
`endif
  localparam logic [7:0] INIT_SEQ [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       init_done;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;

  int tests_run = 0;
  int tests_failed = 0;

  logic [8:0] en_q [$];

  lcd_byte_writer #(
    .TICK_DIV     (TICK),
    .POWERUP_US   (PWR),
    .SETUP_US     (SU),
    .E_HIGH_US    (EH),
    .EXEC_US      (EX),
    .SLOW_EXEC_US (SL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_rs     (wr_rs),
    .wr_data   (wr_data),
    .init_done (init_done),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en),
    .lcd_data  (lcd_data)
  );

  always #5 clk = ~clk;

  // Record what the LCD sees on every E rising edge.
  always @(posedge lcd_en) en_q.push_back({lcd_rs, lcd_data});

  // Reference: a write takes setup + E high + execution time; Clear/Home (rs=0, byte<=3) is slow.
  function automatic int model_latency(input logic rs, input logic [7:0] d);
    int exec_us;
    exec_us = (rs == 1'b0 && d <= 8'd3) ? SL : EX;
    return (SU + EH + exec_us) * TICK;
  endfunction

  function automatic int expected_ready();
    int t;
    t = PW_CYC;
    for (int i = 0; i < N_INIT; i++) t += model_latency(1'b0, INIT_SEQ[i]);
    return t;
  endfunction

  // Performs one write and measures its timing relative to the accept edge.
  task automatic do_write(input logic rs, input logic [7:0] d, output int lat,
                          output int en_start, output int en_len, output logic [8:0] seen,
                          output logic rdy_after, output bit stable);
    int w;
    w = 0;
    while (wr_ready !== 1'b1 && w < MAX_LAT) begin
      @(posedge clk); #1; w++;
    end
    wr_valid = 1'b1; wr_rs = rs; wr_data = d;
    @(posedge clk); #1;
    seen = {lcd_rs, lcd_data};
    rdy_after = wr_ready;
    wr_valid = 1'b0; wr_rs = 1'($urandom_range(1, 0)); wr_data = 8'($urandom);
    lat = -1; en_start = -1; en_len = 0; stable = 1'b1;
    for (int c = 1; c <= MAX_LAT; c++) begin
      @(posedge clk); #1;
      if (lcd_en === 1'b1) begin
        if (en_start < 0) en_start = c;
        en_len++;
      end
      if ({lcd_rs, lcd_data} !== seen) stable = 1'b0;
      if (wr_ready === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  // Releases reset and returns the cycle on which wr_ready first reads 1.
  task automatic run_powerup(output int rise_c, output bit quiet_ok);
    rise_c = -1; quiet_ok = 1'b1;
    rst_n = 1'b1;
    for (int c = 1; c <= expected_ready() + 50; c++) begin
      @(posedge clk); #1;
      if (c < PW_CYC && {wr_ready, init_done, lcd_rs, lcd_rw, lcd_en, lcd_data} !== 13'h0)
        quiet_ok = 1'b0;
      if (wr_ready === 1'b1) begin
        rise_c = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int rise_c;
    bit quiet_ok;
    rst_n = 1'b0; wr_valid = 1'b0; wr_rs = 1'b0; wr_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({wr_ready, init_done, lcd_rs, lcd_rw, lcd_en, lcd_data} !== 13'h0) begin
      tests_failed++;
      $display("FAIL reset_values: got %b, want all zero",
               {wr_ready, init_done, lcd_rs, lcd_rw, lcd_en, lcd_data});
    end
    en_q.delete();
    run_powerup(rise_c, quiet_ok);
    tests_run++;
    if (quiet_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL powerup_quiet: outputs moved during power-up wait");
    end
    tests_run++;
    if (rise_c !== expected_ready()) begin
      tests_failed++;
      $display("FAIL powerup_ready_cycle: got %0d, want %0d", rise_c, expected_ready());
    end
    tests_run++;
    if (init_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL init_done: got %b, want 1", init_done);
    end
    tests_run++;
    if (en_q.size() !== N_INIT) begin
      tests_failed++;
      $display("FAIL init_pulse_count: got %0d, want %0d", en_q.size(), N_INIT);
    end
    for (int i = 0; i < N_INIT && i < en_q.size(); i++) begin
      tests_run++;
      if (en_q[i] !== {1'b0, INIT_SEQ[i]}) begin
        tests_failed++;
        $display("FAIL init_byte_%0d: got %h, want %h", i, en_q[i], {1'b0, INIT_SEQ[i]});
      end
    end
  endtask

  task automatic test_single_write();
    int lat, en_start, en_len;
    logic [8:0] seen;
    logic rdy_after;
    bit stable;
    en_q.delete();
    do_write(1'b1, 8'h41, lat, en_start, en_len, seen, rdy_after, stable);
    tests_run++;
    if (seen !== 9'h141) begin
      tests_failed++; $display("FAIL write_latch: got %h, want 141", seen);
    end
    tests_run++;
    if (rdy_after !== 1'b0) begin
      tests_failed++; $display("FAIL ready_drop: got %b, want 0", rdy_after);
    end
    tests_run++;
    if (en_start !== SU * TICK) begin
      tests_failed++; $display("FAIL en_start: got %0d, want %0d", en_start, SU * TICK);
    end
    tests_run++;
    if (en_len !== EH * TICK) begin
      tests_failed++; $display("FAIL en_width: got %0d, want %0d", en_len, EH * TICK);
    end
    tests_run++;
    if (lat !== model_latency(1'b1, 8'h41)) begin
      tests_failed++;
      $display("FAIL write_latency: got %0d, want %0d", lat, model_latency(1'b1, 8'h41));
    end
    tests_run++;
    if (stable !== 1'b1 || lcd_rw !== 1'b0) begin
      tests_failed++; $display("FAIL bus_stable: stable %b rw %b, want 1 0", stable, lcd_rw);
    end
    tests_run++;
    if (en_q.size() !== 1 || en_q[0] !== 9'h141) begin
      tests_failed++; $display("FAIL en_capture: got %0d pulses, want one of 141", en_q.size());
    end
  endtask

  task automatic test_slow_cmds();
    logic [8:0] cases [7] = '{9'h001, 9'h002, 9'h080, 9'h000, 9'h003, 9'h004, 9'h101};
    int lat, en_start, en_len;
    logic [8:0] seen;
    logic rdy_after;
    bit stable;
    for (int i = 0; i < 7; i++) begin
      do_write(cases[i][8], cases[i][7:0], lat, en_start, en_len, seen, rdy_after, stable);
      tests_run++;
      if (lat !== model_latency(cases[i][8], cases[i][7:0]) || seen !== cases[i]) begin
        tests_failed++;
        $display("FAIL cmd_%h: latency %0d bus %h, want %0d %h", cases[i], lat, seen,
                 model_latency(cases[i][8], cases[i][7:0]), cases[i]);
      end
    end
  endtask

  task automatic test_random();
    int lat, en_start, en_len;
    logic [8:0] seen;
    logic rdy_after;
    bit stable;
    logic rs;
    logic [7:0] d;
    for (int i = 0; i < 12; i++) begin
      rs = 1'($urandom_range(1, 0));
      d = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(3, 0)) : 8'($urandom);
      do_write(rs, d, lat, en_start, en_len, seen, rdy_after, stable);
      tests_run++;
      if (lat !== model_latency(rs, d) || seen !== {rs, d} || en_len !== EH * TICK
          || stable !== 1'b1) begin
        tests_failed++;
        $display("FAIL random_%0d: rs %b data %h latency %0d bus %h en %0d stable %b, want %0d %h %0d 1",
                 i, rs, d, lat, seen, en_len, stable, model_latency(rs, d), {rs, d}, EH * TICK);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1, d2;
    logic rs2;
    int lat, lat2, w;
    bit stable;
    w = 0;
    while (wr_ready !== 1'b1 && w < MAX_LAT) begin
      @(posedge clk); #1; w++;
    end
    d1 = 8'($urandom) | 8'h10;
    wr_valid = 1'b1; wr_rs = 1'b1; wr_data = d1;
    @(posedge clk); #1;
    stable = ({lcd_rs, lcd_data} === {1'b1, d1});
    lat = -1;
    for (int c = 1; c <= MAX_LAT; c++) begin
      wr_rs = 1'($urandom_range(1, 0));
      wr_data = 8'($urandom);
      @(posedge clk); #1;
      if ({lcd_rs, lcd_data} !== {1'b1, d1}) stable = 1'b0;
      if (wr_ready === 1'b1) begin
        lat = c;
        break;
      end
    end
    tests_run++;
    if (stable !== 1'b1 || lat !== model_latency(1'b1, d1)) begin
      tests_failed++;
      $display("FAIL hold_first: stable %b latency %0d, want 1 %0d", stable, lat,
               model_latency(1'b1, d1));
    end
    d2 = wr_data; rs2 = wr_rs;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    tests_run++;
    if ({lcd_rs, lcd_data} !== {rs2, d2} || wr_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_second: bus %h ready %b, want %h 0", {lcd_rs, lcd_data}, wr_ready,
               {rs2, d2});
    end
    lat2 = -1;
    for (int c = 1; c <= MAX_LAT; c++) begin
      @(posedge clk); #1;
      if (wr_ready === 1'b1) begin
        lat2 = c;
        break;
      end
    end
    tests_run++;
    if (lat2 !== model_latency(rs2, d2)) begin
      tests_failed++;
      $display("FAIL hold_second_latency: got %0d, want %0d", lat2, model_latency(rs2, d2));
    end
  endtask

  task automatic test_reset_mid_write();
    int rise_c, w;
    bit quiet_ok;
    w = 0;
    while (wr_ready !== 1'b1 && w < MAX_LAT) begin
      @(posedge clk); #1; w++;
    end
    wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'($urandom);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    w = 0;
    while (lcd_en !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    tests_run++;
    if (lcd_en !== 1'b1) begin
      tests_failed++; $display("FAIL midwrite_en_seen: got %b, want 1", lcd_en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (lcd_en !== 1'b0 || wr_ready !== 1'b0 || lcd_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL async_abort: en %b ready %b data %h, want 0 0 00", lcd_en, wr_ready, lcd_data);
    end
    @(posedge clk); #1;
    run_powerup(rise_c, quiet_ok);
    tests_run++;
    if (quiet_ok !== 1'b1 || rise_c !== expected_ready()) begin
      tests_failed++;
      $display("FAIL repowerup: quiet %b ready cycle %0d, want 1 %0d", quiet_ok, rise_c,
               expected_ready());
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_slow_cmds();
    test_random();
    test_back_to_back();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
